mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit for the EX stage. It executes MULT, MULTU, DIV and DIVU
//  into the architectural HI/LO registers, and also executes MTHI and MTLO.
//  Generalises the combinational ALU to a parametrised, multi-cycle datapath with a start/busy/done
//  handshake and a cancel input for branch-mispredict flush. The hazard unit stalls on busy.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each; must be >= 4
//  CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  start        in   1      request; sampled only when busy=0
//  op           in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored
//  a            in   WIDTH  rs operand (dividend / multiplicand / MTxx source)
//  b            in   WIDTH  rt operand (divisor / multiplier)
//  cancel       in   1      flush; aborts the in-flight operation
//  hi, lo       out  WIDTH  architectural HI/LO registers
//  busy         out  1      operation in flight
//  done         out  1      one-cycle pulse; HI/LO were updated at this edge
//  div_by_zero  out  1      qualified by done; set for DIV/DIVU with b==0
// BEHAVIOUR
//  - Reset: hi=lo=0, busy=0, done=0, div_by_zero=0, state=IDLE.
//  - Assertion is asynchronous; release is clocked.
//  - States: IDLE -> RUN -> FIX -> IDLE.
//  - Accept edge: start=1, busy=0, cancel=0, op is 0-3 or 4-5.
//      - op 0-3: latch operand magnitudes and the result signs, count=0, go to RUN, busy=1.
//      - op 4/5: write hi=a or lo=a at the same edge; done=1, busy never rises.
//      - op 6-7: no effect.
//  - RUN: one iteration per edge for WIDTH edges.
//      - Multiply: radix-2 shift-add on magnitudes.
//      - Divide: restoring, one quotient bit per edge.
//      - After iteration WIDTH-1, go to FIX.
//  - FIX edge: apply sign correction; write {hi,lo}; done=1, busy=0; go to IDLE.
//  - Latency: done is seen after edge WIDTH+2, where edge 1 is the accept edge (34 for WIDTH=32).
//  - Back-to-back: a start in the done cycle is accepted.
//  - start while busy=1: ignored; no queueing.
//  - Signed multiply: {hi,lo} = full 2*WIDTH-bit two's-complement product.
//  - Unsigned multiply: {hi,lo} = unsigned product.
//  - Divide: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
//  - DIV of most-negative by -1: lo=most-negative, hi=0; no trap.
//  - Divide by zero: detected at the accept edge, RUN is skipped.
//      - The next edge performs FIX: hi=a, lo=all ones, div_by_zero=1, done=1.
//  - cancel=1 at any edge with busy=1: go to IDLE, busy=0, no done, hi/lo unchanged.
//  - cancel and start in the same cycle: cancel wins; the start is dropped.
//  - done and div_by_zero are low in every cycle not stated above.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined:
//    - MULT/MULTU are computed in the accept cycle with a single-cycle WIDTHxWIDTH multiplier.
//    - The unit goes straight to FIX, so done is seen after edge 2.
//    - Divide timing is unchanged.
//  MDU_FAST_MUL_EN undefined: the iterative multiply above is used; there is no multiplier
//    cell in the netlist.
// TESTING (WIDTH=32)
//  1. MULT a=0xFFFFFFFD, b=7 -> after edge 34: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle;
//     busy high edges 1-33.
//  2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//     With MDU_FAST_MUL_EN: same values, done after edge 2.
//  3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU a=7, b=2 -> lo=3, hi=1.
//     DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. DIV a=5, b=0 -> done and div_by_zero after edge 2, hi=5, lo=0xFFFFFFFF.
//     Follow with MTHI a=0x1234 -> hi=0x1234 at the accept edge, done=1, busy=0.
//  5. Start DIVU, raise cancel at edge 10 -> busy=0 at edge 10, no done, hi/lo keep prior values.
//     A start while busy=1 leaves all results unchanged.
//  6. Assert rst mid-multiply (between edges) -> immediately hi=lo=0, busy=done=0.
//     After release, a new MULTU 3*5 gives lo=15, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding the architectural HI/LO registers, with MTHI/MTLO.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU in the accept cycle with a full multiplier.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start is sampled only while busy=0; done is a one-cycle pulse marking
  // the edge at which HI/LO changed; cancel at any busy edge drops the operation.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_up;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;

  logic             w_accept;
  logic             w_md_op;
  logic             w_mt_op;
  logic             w_signed;
  logic             w_is_div;
  logic             w_dbz;
  logic             w_fast;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH+1:0] w_div_diff;
  logic             w_div_ok;
  logic [2*WIDTH-1:0] w_full;
  logic [2*WIDTH-1:0] w_full_neg;

  assign w_accept = start && (r_state == S_IDLE) && !cancel && (op <= 3'd5);
  assign w_md_op  = w_accept && !op[2];
  assign w_mt_op  = w_accept && op[2];
  assign w_signed = !op[0];
  assign w_is_div = op[1];
  assign w_dbz    = w_is_div && (b == '0);
  assign w_a_neg  = w_signed && a[WIDTH-1];
  assign w_b_neg  = w_signed && b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
  assign w_fast = !w_is_div;
`else
  assign w_fast = 1'b0;
`endif

  // Multiply step: conditionally add the multiplicand to the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_up} + ({1'b0, r_opnd} & {(WIDTH + 1){r_lo[0]}});
  // Divide step: trial-subtract the divisor from the partial remainder shifted left by one.
  assign w_div_diff = {1'b0, r_up, r_lo[WIDTH-1]} - {2'b00, r_opnd};
  assign w_div_ok   = !w_div_diff[WIDTH+1];
  assign w_full     = {r_up, r_lo};
  assign w_full_neg = -w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_md_op) w_next = (w_dbz || w_fast) ? S_FIX : S_RUN;
      S_RUN: begin
        if (cancel)                 w_next = S_IDLE;
        else if (r_cnt == LAST_CNT) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_up        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mt_op) begin
            if (op[0]) lo <= a;
            else       hi <= a;
            done <= 1'b1;
          end
          if (w_md_op) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_dbz    <= w_dbz;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_dbz) begin
              r_up <= a;
              r_lo <= '1;
            end else if (w_is_div) begin
              r_up   <= '0;
              r_lo   <= w_a_mag;
              r_opnd <= w_b_mag;
            end else begin
`ifdef MDU_FAST_MUL_EN
              {r_up, r_lo} <= w_prod;
`else
              r_up   <= '0;
              r_lo   <= w_b_mag;
              r_opnd <= w_a_mag;
`endif
            end
          end
        end
        S_RUN: begin
          if (!cancel) begin
            r_cnt <= r_cnt + ONE_CNT;
            if (r_is_div) begin
              r_up <= w_div_ok ? w_div_diff[WIDTH-1:0] : {r_up[WIDTH-2:0], r_lo[WIDTH-1]};
              r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
            end else begin
              r_up <= w_mul_sum[WIDTH:1];
              r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!cancel) begin
            done        <= 1'b1;
            div_by_zero <= r_dbz;
            if (r_dbz) begin
              hi <= r_up;
              lo <= r_lo;
            end else if (r_is_div) begin
              // Quotient truncates toward zero; remainder follows the dividend's sign.
              lo <= r_neg_q ? -r_lo : r_lo;
              hi <= r_neg_r ? -r_up : r_up;
            end else begin
              {hi, lo} <= r_neg_q ? w_full_neg : w_full;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a cycle-level reference model checked every cycle plus directed literals.
module tb_mult_div_unit;
  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = W + 2;
`endif
  localparam int LAT_DIV = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a multiply/divide: {div_by_zero, hi, lo}.
  function automatic logic [64:0] ref_md(input logic [2:0] f_op, input logic [W-1:0] fa,
                                         input logic [W-1:0] fb);
    logic [63:0] p;
    int sq;
    int sr;
    p = '0;
    case (f_op)
      3'd0: begin
        p = longint'($signed(fa)) * longint'($signed(fb));
        return {1'b0, p};
      end
      3'd1: begin
        p = {32'd0, fa} * {32'd0, fb};
        return {1'b0, p};
      end
      3'd2: begin
        if (fb == 0) return {1'b1, fa, 32'hFFFF_FFFF};
        if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        sq = $signed(fa) / $signed(fb);
        sr = $signed(fa) % $signed(fb);
        return {1'b0, 32'(sr), 32'(sq)};
      end
      3'd3: begin
        if (fb == 0) return {1'b1, fa, 32'hFFFF_FFFF};
        return {1'b0, fa % fb, fa / fb};
      end
      default: return '0;
    endcase
  endfunction

  // Edges from acceptance until the result edge (inclusive of that edge, excluding accept).
  function automatic int ref_left(input logic [2:0] f_op, input logic [W-1:0] fb);
`ifdef MDU_FAST_MUL_EN
    if (!f_op[1]) return 1;
`endif
    if (f_op[1] && fb == 0) return 1;
    return W + 1;
  endfunction

  logic [W-1:0] m_hi, m_lo, m_res_hi, m_res_lo;
  logic         m_busy, m_done, m_dbz, m_res_dbz;
  int           m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_left <= 0; m_res_hi <= '0; m_res_lo <= '0; m_res_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_busy) begin
        if (cancel) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_dbz <= m_res_dbz;
          m_hi <= m_res_hi; m_lo <= m_res_lo;
        end else m_left <= m_left - 1;
      end else if (start && !cancel) begin
        if (op == 3'd4) begin m_hi <= a; m_done <= 1'b1; end
        else if (op == 3'd5) begin m_lo <= a; m_done <= 1'b1; end
        else if (op <= 3'd3) begin
          {m_res_dbz, m_res_hi, m_res_lo} <= ref_md(op, a, b);
          m_left <= ref_left(op, b);
          m_busy <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_hi", 64'(hi), 64'(m_hi));
    chk("cyc_lo", 64'(lo), 64'(m_lo));
    chk("cyc_busy", 64'(busy), 64'(m_busy));
    chk("cyc_done", 64'(done), 64'(m_done));
    chk("cyc_dbz", 64'(div_by_zero), 64'(m_dbz));
  end

  // Called at a negedge; leaves the bench at the negedge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  int cyc;
  int guard;
  logic [2:0]   r_o;
  logic [W-1:0] r_x, r_y;

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc);
    chk("mult_lat", 64'(cyc), 64'(LAT_MUL));
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
    @(negedge clk);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("multu_lat", 64'(cyc), 64'(LAT_MUL));
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h1);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    chk("div_lat", 64'(cyc), 64'(LAT_DIV));
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2);
    wait_done(cyc);
    chk("divu_lo", 64'(lo), 64'd3);
    chk("divu_hi", 64'(hi), 64'd1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("divovf_lo", 64'(lo), 64'h8000_0000);
    chk("divovf_hi", 64'(hi), 64'd0);

    issue(3'd2, 32'd5, 32'd0);
    wait_done(cyc);
    chk("dbz_lat", 64'(cyc), 64'd2);
    chk("dbz_flag", 64'(div_by_zero), 64'd1);
    chk("dbz_hi", 64'(hi), 64'd5);
    chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
    issue(3'd4, 32'h1234, 32'd0);
    wait_done(cyc);
    chk("mthi_lat", 64'(cyc), 64'd1);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);

    issue(3'd3, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hi", 64'(hi), 64'h1234);
    chk("cancel_lo", 64'(lo), 64'hFFFF_FFFF);
    repeat (40) @(negedge clk);

    issue(3'd3, 32'd100, 32'd7);
    start = 1'b1; op = 3'd0; a = 32'hFFFF; b = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("ignore_lo", 64'(lo), 64'd14);
    chk("ignore_hi", 64'(hi), 64'd2);
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hBEEF; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_hi", 64'(hi), 64'd2);
    chk("cancel_start_done", 64'(done), 64'd0);

    issue(3'd0, 32'd12345, 32'd6789);
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'd1, 32'd3, 32'd5);
    wait_done(cyc);
    chk("post_rst_lo", 64'(lo), 64'd15);
    chk("post_rst_hi", 64'(hi), 64'd0);
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      r_o = 3'($urandom_range(0, 7));
      r_x = $urandom;
      r_y = $urandom;
      case ($urandom_range(0, 9))
        0: r_y = '0;
        1: begin r_x = 32'h8000_0000; r_y = 32'hFFFF_FFFF; end
        2: begin r_x = 32'($urandom_range(0, 40)); r_y = 32'($urandom_range(1, 9)); end
        3: r_y = -32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(r_o, r_x, r_y);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
      end
      guard = 0;
      while (busy && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("drain_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
